// File: rtl/joypad_pkg.sv
// Shared definitions for the NES-style joypad poller: FSM states, button
// bit positions and the opposing-direction mask.
package joypad_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETTLE = 3'd2,
    CLK_LO = 3'd3,
    CLK_HI = 3'd4,
    DONE   = 3'd5
  } joypad_state_t;

  // Bit positions in the parallel button vector (same order as the pad
  // shifts them out, and as the downstream controller model expects).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // A worn pad can report both directions of a pair at once; games tend to
  // misbehave on that, so a pressed pair is reported as neither pressed.
  function automatic logic [7:0] mask_opposing(input logic [7:0] b);
    logic [7:0] m;
    m = b;
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      m[BTN_UP]   = 1'b0;
      m[BTN_DOWN] = 1'b0;
    end
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      m[BTN_LEFT]  = 1'b0;
      m[BTN_RIGHT] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/joypad_poller.sv
// Periodically reads an NES-style serial pad (latch, then 7 clock pulses)
// and publishes the eight buttons as an active-high parallel vector.
module joypad_poller
  import joypad_pkg::*;
#(
  parameter int POLL_PERIOD   = 357955,
  parameter int LATCH_CYCLES  = 258,
  parameter int HALF_BIT      = 129,
  parameter bit MASK_OPPOSING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] btns,
  output logic       btns_valid
);

  localparam int PER_W   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int CNT_MAX = (LATCH_CYCLES > HALF_BIT) ? LATCH_CYCLES : HALF_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_BIT - 1);

  joypad_state_t    r_state;
  joypad_state_t    w_state_nxt;
  logic [PER_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_btns_load;
  logic             r_pad_latch;
  logic             r_pad_clk;
  logic [7:0]       r_btns;
  logic             r_btns_valid;
  logic             w_sync_data;
  logic             w_tick;
  logic             w_last;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pad_data),
    .o_q (w_sync_data)
  );

  // Free-running poll period counter; a poll may only start on its wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= '0;
    end else if (r_period == PER_LAST) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + PER_W'(1);
    end
  end

  assign w_tick = (r_period == PER_LAST) && enable && (r_state == IDLE);

  assign w_last = ((r_state == LATCH) && (r_cnt == LATCH_LAST)) ||
                  (((r_state == SETTLE) || (r_state == CLK_LO) || (r_state == CLK_HI)) &&
                   (r_cnt == HALF_LAST));

  // Next state, bit index and capture of each button on its last sample cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    case (r_state)
      IDLE: begin
        if (w_tick) w_state_nxt = LATCH;
      end
      LATCH: begin
        if (w_last) w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (w_last) begin
          w_shift_nxt[0] = ~w_sync_data;
          w_idx_nxt      = 3'd1;
          w_state_nxt    = CLK_LO;
        end
      end
      CLK_LO: begin
        if (w_last) w_state_nxt = CLK_HI;
      end
      CLK_HI: begin
        if (w_last) begin
          w_shift_nxt[r_idx] = ~w_sync_data;
          if (r_idx == 3'd7) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = CLK_LO;
          end
        end
      end
      DONE: begin
        w_idx_nxt   = 3'd0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_btns_load = MASK_OPPOSING ? mask_opposing(w_shift_nxt) : w_shift_nxt;

  // State register, in-state cycle counter and capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Pad pins and results are registered from the next state so they are
  // glitch-free and line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pad_latch  <= 1'b0;
      r_pad_clk    <= 1'b1;
      r_btns       <= 8'h00;
      r_btns_valid <= 1'b0;
    end else begin
      r_pad_latch  <= (w_state_nxt == LATCH);
      r_pad_clk    <= (w_state_nxt != CLK_LO);
      r_btns_valid <= (w_state_nxt == DONE);
      if (w_state_nxt == DONE) begin
        r_btns <= w_btns_load;
      end
    end
  end

  // Parameter sanity: data must settle through the synchroniser inside a
  // half bit, and a full poll must fit inside one period.
  always_ff @(posedge clk) begin
    assert (HALF_BIT >= 3);
    assert (POLL_PERIOD > LATCH_CYCLES + 15 * HALF_BIT + 2);
  end

  assign pad_latch  = r_pad_latch;
  assign pad_clk    = r_pad_clk;
  assign btns       = r_btns;
  assign btns_valid = r_btns_valid;

endmodule

// File: tb/tb_joypad_poller.sv
// Directed bench for joypad_poller with a behavioural serial pad model.
module tb_joypad_poller;
  import joypad_pkg::*;

  localparam int P   = 400;
  localparam int L   = 8;
  localparam int H   = 4;
  localparam int LAT = L + 15 * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] btns;
  logic       btns_valid;
  logic       nm_latch;
  logic       nm_clk;
  logic [7:0] nm_btns;
  logic       nm_valid;

  logic [7:0] pattern  = 8'hFF;
  logic       tie_high = 1'b0;
  logic [7:0] pad_sr   = 8'hFF;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_fall   = 0;
  int n_latch  = 0;
  int n_vld    = 0;
  logic prev_clk   = 1'b1;
  logic prev_latch = 1'b0;

  joypad_poller #(
    .POLL_PERIOD (P), .LATCH_CYCLES (L), .HALF_BIT (H), .MASK_OPPOSING (1'b1)
  ) dut (
    .clk (clk), .rst (rst), .enable (enable), .pad_data (pad_data),
    .pad_latch (pad_latch), .pad_clk (pad_clk), .btns (btns), .btns_valid (btns_valid)
  );

  joypad_poller #(
    .POLL_PERIOD (P), .LATCH_CYCLES (L), .HALF_BIT (H), .MASK_OPPOSING (1'b0)
  ) dut_nm (
    .clk (clk), .rst (rst), .enable (enable), .pad_data (pad_data),
    .pad_latch (nm_latch), .pad_clk (nm_clk), .btns (nm_btns), .btns_valid (nm_valid)
  );

  always #5 clk = ~clk;

  // Pad: parallel load while latched, shift toward bit 0 on pad_clk rise.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_sr = pattern;
    else           pad_sr = {1'b1, pad_sr[7:1]};
  end
  assign pad_data = tie_high | pad_sr[0];

  always @(posedge clk) cyc++;

  // Activity monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (prev_clk && !pad_clk) n_fall++;
    if (!prev_latch && pad_latch) n_latch++;
    if (btns_valid) n_vld++;
    prev_clk   = pad_clk;
    prev_latch = pad_latch;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [7:0] btn(input int i);
    return 8'(1 << i);
  endfunction

  task automatic wait_latch(input string tag, input int budget, output int d);
    d = 0;
    while (pad_latch !== 1'b1 && d < budget) begin
      @(negedge clk);
      d++;
    end
    if (pad_latch !== 1'b1) chk({tag, "_start_timeout"}, int'(pad_latch), 1);
  endtask

  task automatic finish_poll(input string tag, input int lat, input logic [7:0] exp,
                             input logic [7:0] exp_nm, output int t_vld);
    int d;
    int f0;
    int v0;
    f0 = n_fall;
    v0 = n_vld;
    d  = 0;
    chk({tag, "_nm_latch"}, int'(nm_latch), 1);
    while (btns_valid !== 1'b1 && d < 2 * LAT) begin
      @(negedge clk);
      d++;
    end
    t_vld = cyc;
    chk({tag, "_latency"}, d, lat);
    chk({tag, "_btns"}, int'(btns), int'(exp));
    chk({tag, "_btns_nomask"}, int'(nm_btns), int'(exp_nm));
    chk({tag, "_nm_valid"}, int'(nm_valid), 1);
    chk({tag, "_nm_clk_idle"}, int'(nm_clk), 1);
    @(negedge clk);
    chk({tag, "_vld_pulse"}, int'(btns_valid), 0);
    chk({tag, "_clk_falls"}, n_fall - f0, 7);
    chk({tag, "_vld_count"}, n_vld - v0, 1);
  endtask

  initial begin
    int d;
    int tv;
    int tv2;
    int t_l;
    int f0;
    int l0;
    int k;
    logic pc;

    // Reset state
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_latch", int'(pad_latch), 0);
    chk("rst_padclk", int'(pad_clk), 1);
    chk("rst_btns", int'(btns), 0);
    chk("rst_valid", int'(btns_valid), 0);
    rst = 1'b0;

    // 1: A + Right
    pattern = ~(btn(BTN_A) | btn(BTN_RIGHT));
    wait_latch("t1", 2 * P, d);
    chk("t1_first_poll_delay", d, P);
    finish_poll("t1", LAT, 8'h81, 8'h81, tv);

    // 2: Up + Down + Start, masked vs unmasked
    pattern = ~(btn(BTN_UP) | btn(BTN_DOWN) | btn(BTN_START));
    wait_latch("t2", P, d);
    finish_poll("t2", LAT, 8'h08, 8'h38, tv);

    // 3: enable low for three periods, then re-enable
    pattern = 8'hFE;
    wait_latch("t3a", P, d);
    t_l = cyc;
    finish_poll("t3a", LAT, 8'h01, 8'h01, tv);
    enable = 1'b0;
    f0 = n_fall;
    l0 = n_latch;
    while (cyc < t_l + 3 * P + 100) @(negedge clk);
    chk("t3_no_latch", n_latch - l0, 0);
    chk("t3_no_padclk", n_fall - f0, 0);
    chk("t3_btns_hold", int'(btns), 8'h01);
    enable = 1'b1;
    pattern = ~btn(BTN_LEFT);
    wait_latch("t3b", P, d);
    chk("t3_restart_phase", cyc - t_l, 4 * P);
    finish_poll("t3b", LAT, 8'h40, 8'h40, tv);

    // 4: reset during CLK_LO of bit 3
    pattern = 8'h7E;
    wait_latch("t4", P, d);
    k  = 0;
    d  = 0;
    pc = pad_clk;
    while (k < 3 && d < LAT) begin
      @(negedge clk);
      d++;
      if (pc && !pad_clk) k++;
      pc = pad_clk;
    end
    chk("t4_in_clk_lo", int'(pad_clk), 0);
    rst = 1'b1;
    #1;
    chk("t4_rst_padclk", int'(pad_clk), 1);
    chk("t4_rst_latch", int'(pad_latch), 0);
    chk("t4_rst_btns", int'(btns), 0);
    chk("t4_rst_valid", int'(btns_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = n_fall;
    pattern = ~(btn(BTN_B) | btn(BTN_SELECT));
    wait_latch("t4r", 2 * P, d);
    chk("t4_restart_delay", d, P);
    chk("t4_quiet_padclk", n_fall - f0, 0);
    finish_poll("t4r", LAT, 8'h06, 8'h06, tv);

    // 5: unplugged pad
    tie_high = 1'b1;
    wait_latch("t5a", P, d);
    finish_poll("t5a", LAT, 8'h00, 8'h00, tv);
    wait_latch("t5b", P, d);
    finish_poll("t5b", LAT, 8'h00, 8'h00, tv2);
    chk("t5_valid_period", tv2 - tv, P);

    // 6: drop enable mid-LATCH
    tie_high = 1'b0;
    pattern = 8'hDF;
    wait_latch("t6", P, d);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    chk("t6_still_latched", int'(pad_latch), 1);
    finish_poll("t6", LAT - 3, 8'h20, 8'h20, tv);
    l0 = n_latch;
    repeat (2 * P) @(negedge clk);
    chk("t6_no_new_poll", n_latch - l0, 0);
    chk("t6_btns_hold", int'(btns), 8'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/joypad_poller.md
Name: joypad_poller

Overview:
Polls a physical NES-style serial gamepad and presents its eight buttons as a parallel active-high vector. It drives the pad latch and clock pins, synchronises the pad data pin and shifts in the eight button bits. It publishes the result once per poll period. Its btns output feeds the CPU-facing controller shift-register model directly downstream, using the same bit order.

Parameters:
POLL_PERIOD, 357955, clocks between poll starts (~60 Hz at 21.477 MHz)
LATCH_CYCLES, 258, clocks pad_latch is held high (~12 us)
HALF_BIT, 129, clocks per half of a pad_clk period (~6 us); must be >= 3
MASK_OPPOSING, 1, when 1, clear Up+Down together and Left+Right together if both bits of a pair are pressed

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
enable  input  1  permits new polls to start
pad_data  input  1  raw serial data from pad, active-low (0 = pressed), asynchronous
pad_latch  output  1  latch pulse to pad
pad_clk  output  1  shift clock to pad, idles high
btns  output  8  0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right; 1 = pressed
btns_valid  output  1  one-cycle pulse when btns is updated

Behaviour:
- Reset (async, any state): pad_latch=0, pad_clk=1, btns=0, btns_valid=0, state IDLE, period counter=0, shift register=0, bit index=0.
- pad_data passes through a 2-FF synchroniser. All samples use the synchronised value.
- Period counter is free-running, counts 0..POLL_PERIOD-1, then wraps.
  - At wrap with enable=1 and state IDLE, a poll starts (tick).
  - At wrap with enable=0, or while a poll is in progress, the tick is dropped.
  - First possible poll starts POLL_PERIOD cycles after reset deasserts.
- State machine:
  - IDLE: pad_latch=0, pad_clk=1. Tick -> LATCH.
  - LATCH: pad_latch=1 for LATCH_CYCLES cycles -> SETTLE.
  - SETTLE: pad_latch=0 for HALF_BIT cycles. On its last cycle, capture bit 0 = ~sync_data. Then -> CLK_LO, bit index=1.
  - CLK_LO: pad_clk=0 for HALF_BIT cycles -> CLK_HI.
  - CLK_HI: pad_clk=1 for HALF_BIT cycles. On its last cycle, capture bit[index] = ~sync_data.
    - If index=7 -> DONE.
    - Otherwise index+1 -> CLK_LO.
  - DONE: one cycle. Load btns from the captured bits (with masking applied) and assert btns_valid -> IDLE.
- Exactly 7 pad_clk low pulses per poll.
- btns_valid rises LATCH_CYCLES + 15*HALF_BIT cycles after the first cycle of pad_latch=1.
- Masking (MASK_OPPOSING=1): if captured bits 4 and 5 are both 1, both become 0; same rule for bits 6 and 7. Applied only at the DONE load.
- btns holds its value between polls and while enable=0.
- enable deasserting mid-poll does not abort the poll; it completes and updates btns.
- An unplugged pad (pull-up, data constantly 1) gives btns=0, and btns_valid still pulses.
- Sim-only assertions:
  - HALF_BIT >= 3 (covers synchroniser latency).
  - POLL_PERIOD > LATCH_CYCLES + 15*HALF_BIT + 2.

Decomposition:
- joypad_pkg holds:
  - state enum: IDLE, LATCH, SETTLE, CLK_LO, CLK_HI, DONE;
  - button index constants BTN_A=0 .. BTN_RIGHT=7, shared with the downstream controller model and bench;
  - a function applying opposing-direction masking.
- One sub-module: sync_2ff (generic 2-flop synchroniser, async active-high reset, reset value 1 = released).

Test Plan:
Bench overrides: POLL_PERIOD=400, LATCH_CYCLES=8, HALF_BIT=4. The pad model is a shift register loaded on pad_latch and advanced on pad_clk rising edges.
1. Pad pressed = A and Right (raw line pattern 8'h7E) -> btns=8'h81. btns_valid pulses exactly once, 68 cycles after pad_latch rises. Exactly 7 pad_clk falling edges.
2. Up+Down+Start pressed, MASK_OPPOSING=1 -> btns=8'h08. Same stimulus with MASK_OPPOSING=0 -> btns=8'h38.
3. enable=0 for 3 periods after a poll that gave 8'h01 -> no pad_latch or pad_clk activity, btns stays 8'h01. Re-enable -> the next wrap starts a poll.
4. Assert rst during CLK_LO of bit 3 -> same cycle: pad_clk=1, pad_latch=0, btns=0, btns_valid=0. After release, no activity for 400 cycles, then a normal poll.
5. pad_data tied high -> btns=8'h00, btns_valid pulses every 400 cycles.
6. Drop enable mid-LATCH -> the poll completes with correct btns. No further polls start.
